// File: rtl/toggle_hs_pkg.sv
// Shared types for the two-phase toggle handshake (initiator and responder sides).
// Main responder FSM states and the ack/req phase encoding live here.
package toggle_hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } resp_state_t;

    typedef enum logic {
        ACK_LO = 1'b0,
        ACK_HI = 1'b1
    } ack_phase_t;

endpackage

// File: rtl/toggle_phase.sv
// Two-state phase FSM: the phase flips on every cycle where flip is high.
// Latency: new phase visible one edge after flip; no backpressure (flip always taken).
// Synchronous active-high reset returns the phase to ACK_LO.
module toggle_phase
    import toggle_hs_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic flip,
    output logic phase
);

    ack_phase_t state_q;
    ack_phase_t state_d;

    always_comb begin
        state_d = state_q;
        if (flip) begin
            state_d = (state_q == ACK_LO) ? ACK_HI : ACK_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACK_LO;
        end else begin
            state_q <= state_d;
        end
    end

    assign phase = state_q;

endmodule

// File: rtl/toggle_req_responder.sv
// Receiving end of a two-phase toggle handshake; presents each request on valid/ready.
// Latency: req flip seen in IDLE -> out_valid next cycle; ack flips on the accept edge.
// Backpressure: out_data held in VALID until out_ready; next capture 2 edges after accept.
module toggle_req_responder
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              ack_tgl,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  xfer_count
);

    resp_state_t       state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              req_cap_q, req_cap_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;
    logic              ack_flip;
    logic              ack_phase;

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        req_cap_d    = req_cap_q;
        overrun_d    = overrun_q;
        xfer_count_d = xfer_count_q;
        ack_flip     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_tgl != ack_phase) begin
                    state_d    = VALID;
                    out_data_d = req_data;
                    req_cap_d  = req_tgl;
                end
            end
            VALID: begin
                if (req_tgl != req_cap_q) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    state_d      = ACK;
                    ack_flip     = 1'b1;
                    xfer_count_d = xfer_count_q + CNT_W'(1);
                end
            end
            ACK: begin
                // A phase change seen here is still flagged, but the request itself
                // survives: ack now equals req_cap, so IDLE re-detects it next cycle.
                if (req_tgl != req_cap_q) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == VALID);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            req_cap_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            req_cap_q    <= req_cap_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    toggle_phase u_ack_phase (
        .clk   (clk),
        .reset (reset),
        .flip  (ack_flip),
        .phase (ack_phase)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign ack_tgl    = ack_phase;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_toggle_req_responder.sv
// Directed bench for toggle_req_responder with a per-cycle behavioural reference.
// A second instance with a 2-bit counter exercises counter wrap on the same stimulus.
module tb_toggle_req_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_tgl;
    logic [7:0] req_data;
    logic       out_ready;

    logic       out_valid, ack_tgl, busy, overrun;
    logic [7:0] out_data, xfer_count;
    logic       out_valid2, ack_tgl2, busy2, overrun2;
    logic [7:0] out_data2;
    logic [1:0] xfer_count2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference: what the handshake must look like, tracked as "request in service"
    // plus a turnaround cycle, with an unbounded transfer total.
    bit         m_serving;
    bit         m_turn;
    logic [7:0] m_data;
    bit         m_cap;
    bit         m_ack;
    bit         m_over;
    int         m_total;

    always #5 clk = ~clk;

    toggle_req_responder #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req_tgl(req_tgl), .req_data(req_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .ack_tgl(ack_tgl), .busy(busy), .overrun(overrun), .xfer_count(xfer_count)
    );

    toggle_req_responder #(.DATA_W(8), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .req_tgl(req_tgl), .req_data(req_data),
        .out_ready(out_ready), .out_valid(out_valid2), .out_data(out_data2),
        .ack_tgl(ack_tgl2), .busy(busy2), .overrun(overrun2), .xfer_count(xfer_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_serving = 0; m_turn = 0; m_data = '0; m_cap = 0;
            m_ack = 0; m_over = 0; m_total = 0;
        end else if (m_turn) begin
            if (req_tgl != m_cap) m_over = 1;
            m_turn = 0;
        end else if (m_serving) begin
            if (req_tgl != m_cap) m_over = 1;
            if (out_ready) begin
                m_serving = 0;
                m_turn    = 1;
                m_ack     = ~m_ack;
                m_total++;
            end
        end else if (req_tgl != m_ack) begin
            m_serving = 1;
            m_data    = req_data;
            m_cap     = req_tgl;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out_valid", {31'b0, out_valid}, {31'b0, m_serving});
            check("model_busy", {31'b0, busy}, {31'b0, (m_serving | m_turn)});
            check("model_ack_tgl", {31'b0, ack_tgl}, {31'b0, m_ack});
            check("model_overrun", {31'b0, overrun}, {31'b0, m_over});
            check("model_xfer_count", {24'b0, xfer_count}, m_total % 256);
            check("model_xfer_count_w2", {30'b0, xfer_count2}, m_total % 4);
            if (m_serving) check("model_out_data", {24'b0, out_data}, {24'b0, m_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack_flip(input logic prev, input string name);
        int n = 0;
        while (ack_tgl == prev && n < 20) begin tick(); n++; end
        check({name, "_ack_timeout"}, {31'b0, (ack_tgl != prev)}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check({name, "_idle_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_tgl = 1'b0; req_data = 8'h00; out_ready = 1'b0;

        // 1: reset and release with no request
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ack_tgl", {31'b0, ack_tgl}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_xfer_count", {24'b0, xfer_count}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_busy", {31'b0, busy}, 32'd0);

        // 2: single transfer with ready already high
        req_data = 8'hA5; req_tgl = 1'b1; out_ready = 1'b1;
        tick();
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_data", {24'b0, out_data}, 32'hA5);
        tick();
        check("single_ack", {31'b0, ack_tgl}, 32'd1);
        check("single_count", {24'b0, xfer_count}, 32'd1);
        tick();

        // 3: backpressure holds data, then one ack flip
        out_ready = 1'b0; req_data = 8'h3C; req_tgl = 1'b0;
        tick();
        req_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_data", {24'b0, out_data}, 32'h3C);
            check("bp_ack", {31'b0, ack_tgl}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_ack_flip", {31'b0, ack_tgl}, 32'd0);
        check("bp_count", {24'b0, xfer_count}, 32'd2);
        tick();

        // 4: four back-to-back requests from a fresh reset; 2-bit counter wraps to 0
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic prev;
            int   n;
            prev = ack_tgl;
            req_data = 8'h10 + 8'(i);
            req_tgl = ~req_tgl;
            n = 0;
            while (!out_valid && n < 20) begin tick(); n++; end
            check("b2b_capture", {24'b0, out_data}, 32'h10 + i);
            wait_ack_flip(prev, "b2b");
            wait_idle("b2b");
        end
        check("b2b_ack_end", {31'b0, ack_tgl}, 32'd0);
        check("b2b_count", {24'b0, xfer_count}, 32'd4);
        check("wrap_count_w2", {30'b0, xfer_count2}, 32'd0);
        check("b2b_no_overrun", {31'b0, overrun}, 32'd0);

        // 5: overrun while VALID; the second phase is still served
        out_ready = 1'b0; req_data = 8'h55; req_tgl = 1'b1;
        tick();
        check("ovr_first_data", {24'b0, out_data}, 32'h55);
        req_data = 8'h66; req_tgl = 1'b0;
        tick();
        check("ovr_flag", {31'b0, overrun}, 32'd1);
        check("ovr_hold_data", {24'b0, out_data}, 32'h55);
        out_ready = 1'b1;
        tick();
        check("ovr_ack", {31'b0, ack_tgl}, 32'd1);
        repeat (2) tick();
        check("ovr_second_valid", {31'b0, out_valid}, 32'd1);
        check("ovr_second_data", {24'b0, out_data}, 32'h66);
        tick();
        wait_idle("ovr");
        check("ovr_sticky", {31'b0, overrun}, 32'd1);
        check("ovr_count", {24'b0, xfer_count}, 32'd6);

        // 6: reset while VALID drops the request
        out_ready = 1'b0; req_data = 8'h99; req_tgl = 1'b1;
        tick();
        check("midrst_pre_valid", {31'b0, out_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_ack", {31'b0, ack_tgl}, 32'd0);
        check("midrst_count", {24'b0, xfer_count}, 32'd0);
        check("midrst_overrun", {31'b0, overrun}, 32'd0);
        reset = 1'b0; req_tgl = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("midrst_idle", {31'b0, busy}, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
